// File: rtl/bcd_seg_display.sv
// Two-digit 7-segment display back-end: double-dabble BCD conversion, overflow LED, heartbeat.
// Latency: 9 cycles from accept to display; value_ready low while busy, no input buffering.
module bcd_seg_display #(
  parameter int TICK_DIV        = 25000000,
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  output logic [6:0] seg_ten,
  output logic [6:0] seg_one,
  output logic       led,
  output logic       ledclk
);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int         CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t        state;
  logic [19:0]   shreg;
  logic [19:0]   adj;
  logic [2:0]    iter;
  logic [CW-1:0] tick_cnt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Nibble-local add-3 correction; 255 fits in three digits so nothing carries out.
  always_comb begin
    adj = shreg;
    if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
    if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[11:8]  >= 4'd5) adj[11:8]  = shreg[11:8]  + 4'd3;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      value_ready <= 1'b1;
      seg_ten     <= SEG_DASH;
      seg_one     <= SEG_DASH;
      led         <= 1'b0;
      iter        <= 3'd0;
      shreg       <= 20'd0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid && value_ready) begin
            shreg       <= {12'd0, value_in};
            iter        <= 3'd0;
            value_ready <= 1'b0;
            state       <= CONV;
          end
        end
        CONV: begin
          shreg <= {adj[18:0], 1'b0};
          iter  <= iter + 3'd1;
          if (iter == 3'd7) state <= LOAD;
        end
        LOAD: begin
          if (shreg[19:16] != 4'd0) begin
            seg_ten <= SEG_DASH;
            seg_one <= SEG_DASH;
            led     <= 1'b1;
          end else begin
            led     <= 1'b0;
            seg_one <= seg_code(shreg[11:8]);
            seg_ten <= (shreg[15:12] == 4'd0 && LEAD_ZERO_BLANK) ? SEG_BLANK
                                                                 : seg_code(shreg[15:12]);
          end
          value_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          value_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Free-running heartbeat, independent of the conversion FSM.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      ledclk   <= 1'b0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
      ledclk   <= ~ledclk;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Randomised and directed bench for bcd_seg_display against an arithmetic digit model.
// Two instances: blanking on with a 4-cycle heartbeat, blanking off with a 1-cycle heartbeat.
module tb_bcd_seg_display;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk50;
  logic       reset;
  logic [7:0] value_in;
  logic       value_valid;
  logic       value_ready, value_ready2;
  logic [6:0] seg_ten, seg_one, seg_ten2, seg_one2;
  logic       led, led2, ledclk, ledclk2;

  int n_vec = 0;
  int n_err = 0;
  int hb_n  = 0;

  logic [6:0] e_ten, e_one, e_ten2;
  logic       e_led;

  bcd_seg_display #(.TICK_DIV(4), .LEAD_ZERO_BLANK(1'b1)) dut (
    .clk50(clk50), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .seg_ten(seg_ten), .seg_one(seg_one),
    .led(led), .ledclk(ledclk)
  );

  bcd_seg_display #(.TICK_DIV(1), .LEAD_ZERO_BLANK(1'b0)) dut2 (
    .clk50(clk50), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready2), .seg_ten(seg_ten2), .seg_one(seg_one2),
    .led(led2), .ledclk(ledclk2)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic set_expect(input int v);
    int tens;
    if (v > 99) begin
      e_ten = DASH; e_one = DASH; e_ten2 = DASH; e_led = 1'b1;
    end else begin
      tens   = v / 10;
      e_one  = seg_of(v % 10);
      e_ten2 = seg_of(tens);
      e_ten  = (tens == 0) ? BLANK : seg_of(tens);
      e_led  = 1'b0;
    end
  endtask

  // Cycle count since reset release; heartbeat level follows from plain division.
  always @(posedge clk50 or posedge reset) begin
    if (reset) hb_n <= 0;
    else       hb_n <= hb_n + 1;
  end

  always @(negedge clk50) begin
    if (!reset) begin
      check("ledclk_div4", {6'd0, ledclk},  7'((hb_n / 4) % 2));
      check("ledclk_div1", {6'd0, ledclk2}, 7'(hb_n % 2));
    end
  end

  // Called at a stable time; returns 1 ns after the accepting edge with valid dropped.
  task automatic accept(input int v);
    int waited = 0;
    value_in    = 8'(v);
    value_valid = 1'b1;
    while (!value_ready && waited < 30) begin
      @(negedge clk50);
      waited++;
    end
    if (!value_ready) check("accept_timeout", {6'd0, value_ready}, 7'd1);
    @(posedge clk50);
    #1 value_valid = 1'b0;
  endtask

  // Old digits must hold for 9 edges, then the new value appears with ready high.
  task automatic track_conv(input int v);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk50);
      check("busy_ready", {6'd0, value_ready}, 7'd0);
      check("hold_ten",   seg_ten, e_ten);
      check("hold_one",   seg_one, e_one);
      check("hold_led",   {6'd0, led}, {6'd0, e_led});
    end
    set_expect(v);
    @(negedge clk50);
    check("ready_back", {6'd0, value_ready}, 7'd1);
    check("ten",        seg_ten,  e_ten);
    check("one",        seg_one,  e_one);
    check("led",        {6'd0, led},  {6'd0, e_led});
    check("ten_nolzb",  seg_ten2, e_ten2);
    check("one_nolzb",  seg_one2, e_one);
    check("led_nolzb",  {6'd0, led2}, {6'd0, e_led});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dir[6] = '{42, 7, 99, 100, 255, 0};
    int v;
    reset = 1'b1; value_valid = 1'b1; value_in = 8'd42;
    e_ten = DASH; e_one = DASH; e_ten2 = DASH; e_led = 1'b0;
    repeat (3) @(negedge clk50);
    check("rst_ten",    seg_ten, DASH);
    check("rst_one",    seg_one, DASH);
    check("rst_led",    {6'd0, led}, 7'd0);
    check("rst_ledclk", {6'd0, ledclk}, 7'd0);
    check("rst_ready",  {6'd0, value_ready}, 7'd1);
    #2 reset = 1'b0; value_valid = 1'b0;
    @(negedge clk50);
    check("no_capture_ready", {6'd0, value_ready}, 7'd1);
    check("no_capture_ten",   seg_ten, DASH);
    #2;

    foreach (dir[i]) begin
      accept(dir[i]);
      track_conv(dir[i]);
    end

    // 34 offered while busy must be ignored; 56 goes in at the first ready cycle.
    accept(12);
    value_in = 8'd34; value_valid = 1'b1;
    track_conv(12);
    value_in = 8'd56;
    accept(56);
    track_conv(56);

    // Reset in the middle of a conversion.
    accept(88);
    repeat (4) @(negedge clk50);
    #2 reset = 1'b1;
    #1;
    check("midrst_ten",   seg_ten, DASH);
    check("midrst_one",   seg_one, DASH);
    check("midrst_led",   {6'd0, led}, 7'd0);
    check("midrst_ready", {6'd0, value_ready}, 7'd1);
    e_ten = DASH; e_one = DASH; e_ten2 = DASH; e_led = 1'b0;
    @(negedge clk50);
    #2 reset = 1'b0;
    accept(5);
    track_conv(5);

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 255));
      accept(v);
      track_conv(v);
    end

    repeat (10) @(negedge clk50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
